// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: merges the player and obstacle pixel-write streams into
// the single VGA adapter write port. Neither source can be stalled, so each
// one feeds its own FIFO. The FIFOs are drained round-robin, one pixel per
// clock. A pixel that arrives at a full FIFO is dropped, and a sticky
// per-source flag records the drop.

module vga_write_fifo #(
    parameter int W     = 28,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          drop
);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          rd_en;
    logic          wr_en;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    // A pop frees the head slot on the same edge, so a full FIFO that is being
    // popped still accepts the incoming entry. That entry reuses the slot.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign drop  = push && full && !rd_en;
    assign head  = mem[rd_ptr];

    // Entry storage holds data only; it needs no reset.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH. The count tracks occupancy.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module vga_write_arbiter #(
    parameter int nX          = 10,
    parameter int nY          = 9,
    parameter int COLOR_DEPTH = 9,
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_AW     = 4
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic [nX-1:0]          p_x,
    input  logic [nY-1:0]          p_y,
    input  logic [COLOR_DEPTH-1:0] p_color,
    input  logic                   p_write,
    input  logic [nX-1:0]          o_x,
    input  logic [nY-1:0]          o_y,
    input  logic [COLOR_DEPTH-1:0] o_color,
    input  logic                   o_write,
    input  logic                   clear_overflow,
    output logic [nX-1:0]          VGA_x,
    output logic [nY-1:0]          VGA_y,
    output logic [COLOR_DEPTH-1:0] VGA_color,
    output logic                   VGA_write,
    output logic                   p_overflow,
    output logic                   o_overflow,
    output logic                   idle
);
    localparam int ENTRY_W = nX + nY + COLOR_DEPTH;

    typedef enum logic {
        SRC_PLAYER   = 1'b0,
        SRC_OBSTACLE = 1'b1
    } src_e;

    logic [ENTRY_W-1:0] p_head;
    logic [ENTRY_W-1:0] o_head;
    logic [FIFO_AW:0]   p_count;
    logic [FIFO_AW:0]   o_count;
    logic               p_empty;
    logic               o_empty;
    logic               p_drop;
    logic               o_drop;
    logic               pop_p;
    logic               pop_o;
    src_e               last_grant;
    src_e               last_grant_next;
    logic [ENTRY_W-1:0] pix_p0;
    logic               vld_p0;
    logic [ENTRY_W-1:0] pix_p1;
    logic               vld_p1;

    vga_write_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_p_fifo (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .push      (p_write),
        .push_data ({p_x, p_y, p_color}),
        .pop       (pop_p),
        .head      (p_head),
        .count     (p_count),
        .empty     (p_empty),
        .drop      (p_drop)
    );

    vga_write_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_o_fifo (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .push      (o_write),
        .push_data ({o_x, o_y, o_color}),
        .pop       (pop_o),
        .head      (o_head),
        .count     (o_count),
        .empty     (o_empty),
        .drop      (o_drop)
    );

    // Round-robin state. Reset points it at the obstacle, so the player wins
    // the first tie.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            last_grant <= SRC_OBSTACLE;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    // Grant on pre-edge occupancy. A pixel pushed this edge is not visible yet.
    always_comb begin
        pop_p           = 1'b0;
        pop_o           = 1'b0;
        last_grant_next = last_grant;
        if (!p_empty && !o_empty) begin
            if (last_grant == SRC_OBSTACLE) begin
                pop_p = 1'b1;
            end else begin
                pop_o = 1'b1;
            end
        end else if (!p_empty) begin
            pop_p = 1'b1;
        end else if (!o_empty) begin
            pop_o = 1'b1;
        end
        if (pop_p) begin
            last_grant_next = SRC_PLAYER;
        end else if (pop_o) begin
            last_grant_next = SRC_OBSTACLE;
        end
    end

    // ---- stage p0: head of the granted FIFO
    assign vld_p0 = pop_p || pop_o;
    assign pix_p0 = pop_p ? p_head : o_head;

    // ---- stage p1: registered write port. Reset also clears the coordinates,
    // so nothing stale appears after a mid-burst reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            vld_p1 <= 1'b0;
            pix_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                pix_p1 <= pix_p0;
            end
        end
    end

    // Sticky drop flags. A drop on the same edge as a clear leaves the flag set.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            p_overflow <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            p_overflow <= p_drop || (p_overflow && !clear_overflow);
            o_overflow <= o_drop || (o_overflow && !clear_overflow);
        end
    end

    assign {VGA_x, VGA_y, VGA_color} = pix_p1;
    assign VGA_write = vld_p1;
    assign idle      = (p_count == '0) && (o_count == '0) && !vld_p1;
endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter. A queue-based model of the two FIFOs and the
// round-robin grant pushes expected pixels into a scoreboard. Each scenario
// task pops the scoreboard and compares it against the DUT output.

module tb_vga_write_arbiter;
    localparam int NX    = 10;
    localparam int NY    = 9;
    localparam int CD    = 9;
    localparam int DEPTH = 16;

    typedef logic [NX+NY+CD-1:0] pix_t;

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic [NX-1:0] p_x = '0;
    logic [NY-1:0] p_y = '0;
    logic [CD-1:0] p_color = '0;
    logic          p_write = 1'b0;
    logic [NX-1:0] o_x = '0;
    logic [NY-1:0] o_y = '0;
    logic [CD-1:0] o_color = '0;
    logic          o_write = 1'b0;
    logic          clear_overflow = 1'b0;
    logic [NX-1:0] VGA_x;
    logic [NY-1:0] VGA_y;
    logic [CD-1:0] VGA_color;
    logic          VGA_write;
    logic          p_overflow;
    logic          o_overflow;
    logic          idle;

    int   n_cmp = 0;
    int   n_bad = 0;
    pix_t mp[$];
    pix_t mo[$];
    pix_t exp_q[$];
    bit   m_last_o = 1'b1;
    bit   m_write = 1'b0;
    bit   m_povf = 1'b0;
    bit   m_oovf = 1'b0;
    int   p_drops = 0;
    int   o_drops = 0;
    int   pushed = 0;

    vga_write_arbiter dut (
        .Clock          (Clock),
        .Resetn         (Resetn),
        .p_x            (p_x),
        .p_y            (p_y),
        .p_color        (p_color),
        .p_write        (p_write),
        .o_x            (o_x),
        .o_y            (o_y),
        .o_color        (o_color),
        .o_write        (o_write),
        .clear_overflow (clear_overflow),
        .VGA_x          (VGA_x),
        .VGA_y          (VGA_y),
        .VGA_color      (VGA_color),
        .VGA_write      (VGA_write),
        .p_overflow     (p_overflow),
        .o_overflow     (o_overflow),
        .idle           (idle)
    );

    always #10 Clock = ~Clock;

    // 0 = no pop, 1 = player, 2 = obstacle, decided on pre-edge model state
    function automatic int pick();
        if (mp.size() != 0 && mo.size() != 0) return m_last_o ? 1 : 2;
        if (mp.size() != 0) return 1;
        if (mo.size() != 0) return 2;
        return 0;
    endfunction

    // Advance the model with the inputs currently driven, then cross one edge
    task automatic tick();
        int sel;
        if (!Resetn) begin
            mp.delete();
            mo.delete();
            exp_q.delete();
            m_last_o = 1'b1;
            m_write  = 1'b0;
            m_povf   = 1'b0;
            m_oovf   = 1'b0;
        end else begin
            sel = pick();
            m_write = (sel != 0);
            if (sel == 1) begin
                exp_q.push_back(mp.pop_front());
                m_last_o = 1'b0;
            end else if (sel == 2) begin
                exp_q.push_back(mo.pop_front());
                m_last_o = 1'b1;
            end
            m_povf = m_povf && !clear_overflow;
            m_oovf = m_oovf && !clear_overflow;
            if (p_write) begin
                pushed++;
                if (mp.size() < DEPTH) mp.push_back({p_x, p_y, p_color});
                else begin m_povf = 1'b1; p_drops++; end
            end
            if (o_write) begin
                pushed++;
                if (mo.size() < DEPTH) mo.push_back({o_x, o_y, o_color});
                else begin m_oovf = 1'b1; o_drops++; end
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        p_write = 1'b0;
        o_write = 1'b0;
        clear_overflow = 1'b0;
        tick();
        Resetn = 1'b1;
        p_drops = 0;
        o_drops = 0;
        pushed = 0;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (VGA_write !== 1'b0) begin n_bad++; $display("FAIL rst_write: got %0b want 0", VGA_write); end
        n_cmp++;
        if ({VGA_x, VGA_y, VGA_color} !== 28'd0) begin
            n_bad++; $display("FAIL rst_pix: got %h want 0", {VGA_x, VGA_y, VGA_color});
        end
        n_cmp++;
        if ({p_overflow, o_overflow} !== 2'b00) begin
            n_bad++; $display("FAIL rst_ovf: got %b want 00", {p_overflow, o_overflow});
        end
        n_cmp++;
        if (idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle: got %0b want 1", idle); end
        Resetn = 1'b1;
        tick();
        n_cmp++;
        if (idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle_after: got %0b want 1", idle); end
    endtask

    task automatic test_latency();
        pix_t want;
        do_reset();
        p_x = 10'd100; p_y = 9'd50; p_color = 9'h1FF; p_write = 1'b1;
        tick();
        p_write = 1'b0;
        n_cmp++;
        if (VGA_write !== 1'b0) begin n_bad++; $display("FAIL lat_early: VGA_write=%0b want 0", VGA_write); end
        n_cmp++;
        if (idle !== 1'b0) begin n_bad++; $display("FAIL lat_idle_queued: got %0b want 0", idle); end
        tick();
        n_cmp++;
        if (VGA_write !== 1'b1) begin n_bad++; $display("FAIL lat_write: VGA_write=%0b want 1", VGA_write); end
        n_cmp++;
        if ({VGA_x, VGA_y, VGA_color} !== {10'd100, 9'd50, 9'h1FF}) begin
            n_bad++; $display("FAIL lat_pix: got %0d/%0d/%h want 100/50/1ff", VGA_x, VGA_y, VGA_color);
        end
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            n_cmp++;
            if ({VGA_x, VGA_y, VGA_color} !== want) begin
                n_bad++; $display("FAIL lat_sb: got %h want %h", {VGA_x, VGA_y, VGA_color}, want);
            end
        end
        n_cmp++;
        if (idle !== 1'b0) begin n_bad++; $display("FAIL lat_idle_busy: got %0b want 0", idle); end
        tick();
        n_cmp++;
        if (VGA_write !== 1'b0) begin n_bad++; $display("FAIL lat_single: VGA_write=%0b want 0", VGA_write); end
        n_cmp++;
        if (idle !== 1'b1) begin n_bad++; $display("FAIL lat_idle_done: got %0b want 1", idle); end
    endtask

    task automatic test_interleave();
        int   exp_col[8];
        int   got_col[8];
        int   n_got;
        int   run;
        int   best;
        int   first;
        pix_t want;
        for (int i = 0; i < 4; i++) begin
            exp_col[2*i]   = 16 + i;
            exp_col[2*i+1] = 288 + i;
        end
        do_reset();
        n_got = 0; run = 0; best = 0; first = -1;
        for (int t = 0; t < 14; t++) begin
            if (t < 4) begin
                p_x = 10'(t); p_y = 9'(t); p_color = 9'(16 + t); p_write = 1'b1;
                o_x = 10'(500 + t); o_y = 9'(300 + t); o_color = 9'(288 + t); o_write = 1'b1;
            end else begin
                p_write = 1'b0;
                o_write = 1'b0;
            end
            tick();
            n_cmp++;
            if (VGA_write !== m_write) begin
                n_bad++; $display("FAIL rr_write t=%0d: got %0b want %0b", t, VGA_write, m_write);
            end
            if (m_write && exp_q.size() != 0) begin
                want = exp_q.pop_front();
                if (VGA_write === 1'b1) begin
                    n_cmp++;
                    if ({VGA_x, VGA_y, VGA_color} !== want) begin
                        n_bad++; $display("FAIL rr_sb: got %h want %h", {VGA_x, VGA_y, VGA_color}, want);
                    end
                end
            end
            if (VGA_write === 1'b1) begin
                if (first < 0) first = t;
                if (n_got < 8) got_col[n_got] = int'(VGA_color);
                n_got++;
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
        end
        n_cmp++;
        if (n_got != 8) begin n_bad++; $display("FAIL rr_count: got %0d want 8", n_got); end
        for (int j = 0; j < 8 && j < n_got; j++) begin
            n_cmp++;
            if (got_col[j] != exp_col[j]) begin
                n_bad++; $display("FAIL rr_order[%0d]: got %h want %h", j, got_col[j], exp_col[j]);
            end
        end
        n_cmp++;
        if (best != 8) begin n_bad++; $display("FAIL rr_consecutive: got %0d want 8", best); end
        n_cmp++;
        if (first != 1) begin n_bad++; $display("FAIL rr_first: got cycle %0d want 1", first); end
    endtask

    task automatic test_overflow();
        int   last_p;
        int   last_o;
        int   emitted;
        pix_t want;
        do_reset();
        last_p = -1; last_o = -1; emitted = 0;
        for (int t = 0; t < 100; t++) begin
            if (t < 40) begin
                p_x = 10'(t); p_y = 9'd1; p_color = 9'h055; p_write = 1'b1;
                o_x = 10'(t); o_y = 9'd2; o_color = 9'h1AA; o_write = 1'b1;
            end else begin
                p_write = 1'b0;
                o_write = 1'b0;
            end
            tick();
            n_cmp++;
            if (VGA_write !== m_write) begin
                n_bad++; $display("FAIL ovf_write t=%0d: got %0b want %0b", t, VGA_write, m_write);
            end
            if (m_write && exp_q.size() != 0) begin
                want = exp_q.pop_front();
                if (VGA_write === 1'b1) begin
                    n_cmp++;
                    if ({VGA_x, VGA_y, VGA_color} !== want) begin
                        n_bad++; $display("FAIL ovf_sb: got %h want %h", {VGA_x, VGA_y, VGA_color}, want);
                    end
                end
            end
            if (VGA_write === 1'b1) begin
                emitted++;
                n_cmp++;
                if (VGA_color == 9'h055) begin
                    if (int'(VGA_x) <= last_p) begin
                        n_bad++; $display("FAIL ovf_p_order: got x=%0d want >%0d", VGA_x, last_p);
                    end
                    last_p = int'(VGA_x);
                end else begin
                    if (int'(VGA_x) <= last_o) begin
                        n_bad++; $display("FAIL ovf_o_order: got x=%0d want >%0d", VGA_x, last_o);
                    end
                    last_o = int'(VGA_x);
                end
            end
        end
        n_cmp++;
        if ({p_overflow, o_overflow} !== 2'b11) begin
            n_bad++; $display("FAIL ovf_flags: got %b want 11", {p_overflow, o_overflow});
        end
        n_cmp++;
        if (p_drops == 0 || o_drops == 0) begin
            n_bad++; $display("FAIL ovf_drops: got p=%0d o=%0d want both >0", p_drops, o_drops);
        end
        n_cmp++;
        if (emitted != 80 - p_drops - o_drops) begin
            n_bad++; $display("FAIL ovf_total: got %0d want %0d", emitted, 80 - p_drops - o_drops);
        end
        n_cmp++;
        if (idle !== 1'b1) begin n_bad++; $display("FAIL ovf_idle: got %0b want 1", idle); end
    endtask

    // 15 joint writes leave 8+8 queued. Player-only writes then grow the player
    // FIFO by one every two edges while the obstacle FIFO drains, so the player
    // reaches 16 just as the obstacle empties.
    task automatic test_full_no_overflow();
        int   emitted;
        int   t;
        bit   reached;
        pix_t want;
        do_reset();
        emitted = 0;
        reached = 1'b0;
        t = 0;
        while (t < 120) begin
            if (t < 15) begin
                o_x = 10'(t); o_y = 9'd7; o_color = 9'h0F0; o_write = 1'b1;
            end else begin
                o_write = 1'b0;
            end
            p_x = 10'(t); p_y = 9'd3; p_color = 9'h00F;
            p_write = (!reached || t < 200) && (t < 60);
            tick();
            n_cmp++;
            if (VGA_write !== m_write) begin
                n_bad++; $display("FAIL full_write t=%0d: got %0b want %0b", t, VGA_write, m_write);
            end
            if (m_write && exp_q.size() != 0) begin
                want = exp_q.pop_front();
                if (VGA_write === 1'b1) begin
                    n_cmp++;
                    if ({VGA_x, VGA_y, VGA_color} !== want) begin
                        n_bad++; $display("FAIL full_sb: got %h want %h", {VGA_x, VGA_y, VGA_color}, want);
                    end
                end
            end
            if (VGA_write === 1'b1) emitted++;
            if (!reached && mp.size() == DEPTH && mo.size() == 0) begin
                reached = 1'b1;
                t = 49;
            end
            t++;
        end
        n_cmp++;
        if (!reached) begin n_bad++; $display("FAIL full_fill: got not-full want 16 entries"); end
        n_cmp++;
        if (p_overflow !== 1'b0) begin n_bad++; $display("FAIL full_p_ovf: got %0b want 0", p_overflow); end
        n_cmp++;
        if (emitted != pushed) begin n_bad++; $display("FAIL full_total: got %0d want %0d", emitted, pushed); end
        n_cmp++;
        if (idle !== 1'b1) begin n_bad++; $display("FAIL full_idle: got %0b want 1", idle); end
    endtask

    task automatic test_clear_overflow();
        int   n;
        bit   found;
        pix_t want;
        do_reset();
        p_x = 10'd1; p_y = 9'd1; p_color = 9'h011; p_write = 1'b1;
        o_x = 10'd2; o_y = 9'd2; o_color = 9'h022; o_write = 1'b1;
        n = 0;
        while (!m_oovf && n < 60) begin
            tick();
            n++;
        end
        n_cmp++;
        if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL clr_set: got %0b want 1", o_overflow); end
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            if (mo.size() == DEPTH && pick() != 2) begin
                clear_overflow = 1'b1;
                tick();
                clear_overflow = 1'b0;
                found = 1'b1;
                n_cmp++;
                if (o_overflow !== 1'b1) begin
                    n_bad++; $display("FAIL clr_setwins: got %0b want 1", o_overflow);
                end
            end else begin
                tick();
            end
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL clr_no_drop_edge: got none want one"); end
        p_write = 1'b0;
        o_write = 1'b0;
        tick();
        n_cmp++;
        if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL clr_sticky: got %0b want 1", o_overflow); end
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        n_cmp++;
        if ({p_overflow, o_overflow} !== 2'b00) begin
            n_bad++; $display("FAIL clr_cleared: got %b want 00", {p_overflow, o_overflow});
        end
        exp_q.delete();
        for (int t = 0; t < 40; t++) begin
            if (exp_q.size() != 0) want = exp_q.pop_front();
            tick();
        end
        n_cmp++;
        if (idle !== 1'b1) begin n_bad++; $display("FAIL clr_idle: got %0b want 1", idle); end
    endtask

    task automatic test_reset_midburst();
        int   n;
        int   pulses;
        pix_t want;
        do_reset();
        n = 0;
        while (mp.size() + mo.size() < 10 && n < 30) begin
            p_x = 10'(n); p_y = 9'd4; p_color = 9'h044; p_write = 1'b1;
            o_x = 10'(n); o_y = 9'd5; o_color = 9'h155; o_write = 1'b1;
            tick();
            n++;
            n_cmp++;
            if (VGA_write !== m_write) begin
                n_bad++; $display("FAIL mid_write: got %0b want %0b", VGA_write, m_write);
            end
            if (m_write && exp_q.size() != 0) begin
                want = exp_q.pop_front();
                if (VGA_write === 1'b1) begin
                    n_cmp++;
                    if ({VGA_x, VGA_y, VGA_color} !== want) begin
                        n_bad++; $display("FAIL mid_sb: got %h want %h", {VGA_x, VGA_y, VGA_color}, want);
                    end
                end
            end
        end
        Resetn = 1'b0;
        p_write = 1'b0;
        o_write = 1'b0;
        tick();
        Resetn = 1'b1;
        n_cmp++;
        if ({VGA_x, VGA_y, VGA_color} !== 28'd0) begin
            n_bad++; $display("FAIL mid_pix: got %h want 0", {VGA_x, VGA_y, VGA_color});
        end
        n_cmp++;
        if (idle !== 1'b1) begin n_bad++; $display("FAIL mid_idle: got %0b want 1", idle); end
        pulses = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (VGA_write !== 1'b0 || idle !== 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin n_bad++; $display("FAIL mid_after: got %0d busy cycles want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_interleave();
        test_overflow();
        test_full_no_overflow();
        test_clear_overflow();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Downstream stage of the obstacle manager and player object: merges their independent fire-and-forget pixel-write streams into the single VGA adapter write port.
- Neither source accepts backpressure, so each source gets its own FIFO.
- Sources are drained with round-robin arbitration, at most one pixel per clock.
- Dropped pixels on overflow are flagged per source.

Parameters:
- nX, 10, VGA x coordinate width
- nY, 9, VGA y coordinate width
- COLOR_DEPTH, 9, pixel colour width
- FIFO_DEPTH, 16, entries per source FIFO (power of two, ≥2)
- FIFO_AW, 4, log2(FIFO_DEPTH)

Ports:
- Clock  in  1  system clock, 50 MHz
- Resetn  in  1  synchronous active-low reset
- p_x  in  nX  player write x
- p_y  in  nY  player write y
- p_color  in  COLOR_DEPTH  player write colour
- p_write  in  1  player write strobe, one pixel per cycle high
- o_x  in  nX  obstacle write x
- o_y  in  nY  obstacle write y
- o_color  in  COLOR_DEPTH  obstacle write colour
- o_write  in  1  obstacle write strobe
- clear_overflow  in  1  clears both sticky overflow flags
- VGA_x  out  nX  merged write x to VGA adapter
- VGA_y  out  nY  merged write y
- VGA_color  out  COLOR_DEPTH  merged write colour
- VGA_write  out  1  merged write strobe
- p_overflow  out  1  sticky: a player pixel was dropped
- o_overflow  out  1  sticky: an obstacle pixel was dropped
- idle  out  1  both FIFOs empty and VGA_write low

Behaviour:
- Reset: Resetn sampled low at a rising edge does the following.
  - Clears both FIFOs (rd/wr pointers and counts = 0).
  - Sets VGA_x, VGA_y, VGA_color and VGA_write to 0.
  - Clears p_overflow and o_overflow.
  - Sets the round-robin pointer last_grant = obstacle, so the player wins the first tie.
  - idle = 1 from the edge after reset.
  - Reset mid-burst discards all queued pixels; no partial write is emitted after reset.
- FIFO entry: {x, y, color}, nX+nY+COLOR_DEPTH = 28 bits. Storage is a register array. Count is FIFO_AW+1 bits; pointers wrap modulo FIFO_DEPTH.
- Push rule: the source strobe is sampled at rising edge k.
  - If count < FIFO_DEPTH, or a pop of that FIFO occurs at the same edge, the entry is written.
  - Otherwise the entry is dropped, the FIFO contents are unchanged, and that source's overflow flag is set at edge k.
- Pop and arbitration, evaluated on pre-edge FIFO state at each edge:
  - Neither FIFO non-empty: no pop; VGA_write <= 0; VGA_x/VGA_y/VGA_color hold their last values.
  - Exactly one FIFO non-empty: pop it.
  - Both non-empty: pop the source not equal to last_grant.
  - On any pop: last_grant <= popped source; VGA_x/y/color <= head entry; VGA_write <= 1.
- Latency: a pixel pushed into an empty FIFO at edge k with no competing source appears on VGA_* with VGA_write=1 during the cycle after edge k+1. There is no combinational bypass.
- Throughput: one output pixel per cycle. With both sources busy, each gets ≥1 slot in every 2 cycles.
- Order: per-source pixel order is preserved exactly. Interleave between sources is defined only by the round-robin rule.
- Simultaneous events:
  - Push and pop on the same FIFO at the same edge: count unchanged. This holds when full as well, so no overflow is flagged.
  - Push into an empty FIFO is not poppable until the next edge.
- Overflow flags:
  - Remain set until clear_overflow=1 or reset.
  - If clear_overflow and a new drop coincide, the flag ends set (set wins).
- idle: combinational, (p_count==0 && o_count==0 && !VGA_write).
- Strobes with VGA_write low carry no meaning for the coordinate/colour outputs; the adapter must ignore them.

Test Plan:
- Reset, then a single p_write with (x=100, y=50, color=0x1FF) at edge 1 -> VGA_write=1 with 100/50/0x1FF only in the cycle after edge 2; idle=0 then, idle=1 one cycle later.
- p_write and o_write both high for 4 cycles with distinct colours P0..P3 and O0..O3 -> output sequence P0,O0,P1,O1,P2,O2,P3,O3 with VGA_write high for 8 consecutive cycles.
- o_write high for 40 cycles while p_write is held high for 40 cycles (FIFO_DEPTH=16) -> both overflow flags set; each source's output pixels are in original order with no duplicates; total emitted = 80 − dropped.
- Fill the player FIFO to 16 entries, then hold p_write for 10 more cycles with o_write low -> pops run concurrently, so no overflow; p_overflow=0.
- Set o_overflow, then pulse clear_overflow on the same edge as a new obstacle drop -> o_overflow remains 1; a later pulse with no drop -> o_overflow=0.
- Assert Resetn=0 for one edge with 10 pixels queued -> no further VGA_write pulses; VGA_x/VGA_y/VGA_color=0; idle=1.
